// File: rtl/calc_method_pkg.sv
// Purpose: shared method codes, FSM state type and code-stepping helper for the
//          calculation-method selector and the display stage.
// Contents: METHOD_* codes, NUM_METHODS, METHOD_W, state_e, method_step().
package calc_method_pkg;

  localparam int unsigned METHOD_W    = 3;
  localparam int unsigned NUM_METHODS = 5;

  localparam logic [METHOD_W-1:0] METHOD_T = METHOD_W'(0);
  localparam logic [METHOD_W-1:0] METHOD_A = METHOD_W'(1);
  localparam logic [METHOD_W-1:0] METHOD_C = METHOD_W'(2);
  localparam logic [METHOD_W-1:0] METHOD_B = METHOD_W'(3);
  localparam logic [METHOD_W-1:0] METHOD_J = METHOD_W'(4);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BROWSE  = 2'd1,
    PENDING = 2'd2
  } state_e;

  // Step a method code by one position, wrapping J <-> T.
  function automatic logic [METHOD_W-1:0] method_step(input logic [METHOD_W-1:0] code,
                                                      input logic                up);
    if (up) begin
      return (code == METHOD_J) ? METHOD_T : code + METHOD_W'(1);
    end
    return (code == METHOD_T) ? METHOD_J : code - METHOD_W'(1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Purpose: synchronize, debounce and edge-detect one raw push-button.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   btn_raw   - asynchronous raw button level
//   level     - debounced button level
//   press     - one-cycle pulse on a debounced rising edge
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q;
  logic             armed_q, armed_d;
  logic [1:0]       fill_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stability counter: level follows the synchronized input only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Presses are only reported once the button has been seen released after
  // reset, so a button held through reset release settles high silently.
  assign armed_d = armed_q | (fill_q[1] & ~sync2_q & ~level_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      armed_q     <= 1'b0;
      fill_q      <= 2'b00;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q & armed_q;
      armed_q     <= armed_d;
      fill_q      <= {fill_q[0], 1'b1};
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/calc_method_select.sv
// Purpose: operator method selector; debounces next/prev/confirm buttons, steps
//          the method code and hands a confirmed method over with valid/ack.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   btn_next, btn_prev, btn_confirm   - raw asynchronous buttons
//   sel_enable                        - top controller is in selection mode
//   method_ack                        - controller accepted the confirmed method
//   method_sel                        - current method code (to display stage)
//   method_valid                      - confirmed method held on method_sel
//   browsing                          - high while browsing (selection LED)
module calc_method_select
  import calc_method_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_next,
  input  logic                btn_prev,
  input  logic                btn_confirm,
  input  logic                sel_enable,
  input  logic                method_ack,
  output logic [METHOD_W-1:0] method_sel,
  output logic                method_valid,
  output logic                browsing
);

  logic [2:0]          unused_levels;
  logic                press_next, press_prev, press_confirm;
  state_e              state_q, state_d;
  logic [METHOD_W-1:0] sel_q, sel_d;
  logic                valid_q, valid_d;
  logic                browsing_q, browsing_d;

  // Debouncers run in every state; presses outside BROWSE are simply ignored.
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst(rst), .btn_raw(btn_next), .level(unused_levels[0]), .press(press_next)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(clk), .rst(rst), .btn_raw(btn_prev), .level(unused_levels[1]), .press(press_prev)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
    .clk(clk), .rst(rst), .btn_raw(btn_confirm), .level(unused_levels[2]), .press(press_confirm)
  );

  // Next-state and output logic. Priority in BROWSE: leaving selection mode,
  // then confirm (freezing the pre-step code), then a single-direction step.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (sel_enable) state_d = BROWSE;
      end
      BROWSE: begin
        if (!sel_enable) begin
          state_d = IDLE;
        end else if (press_confirm) begin
          state_d = PENDING;
          valid_d = 1'b1;
        end else if (press_next ^ press_prev) begin
          sel_d = method_step(sel_q, press_next);
        end
      end
      PENDING: begin
        if (method_ack) begin
          valid_d = 1'b0;
          state_d = sel_enable ? BROWSE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    // Recover from an out-of-range code left by an upset.
    if (sel_q > METHOD_W'(NUM_METHODS - 1)) sel_d = METHOD_T;
    browsing_d = (state_d == BROWSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= METHOD_T;
      valid_q    <= 1'b0;
      browsing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      browsing_q <= browsing_d;
    end
  end

  assign method_sel   = sel_q;
  assign method_valid = valid_q;
  assign browsing     = browsing_q;

endmodule
